fsub_err: RTL and testbench
===========================

// Module: fsub_err
// PURPOSE
//  Pipelined fixed-point error subtractor for the adaptive-filter datapath: e = d - y (Q1.FRAC).
//  Counterpart to the signed adder: subtracts instead of adds, and adds overflow handling and statistics.
//  Sits between the FIR output and the LMS coefficient-update stage.
//  Uses valid/ready handshakes on both sides, a 2-stage pipeline, a sticky overflow flag and an overflow counter.
// PARAMETERS
//  WIDTH  16  sample width, two's complement
//  FRAC   15  fractional bits (informational; arithmetic is format-agnostic)
//  CNT_W  8   width of the overflow event counter
// PORTS
//  i_clk        in   1       clock, all logic on rising edge
//  i_rst        in   1       synchronous reset, active-high
//  i_valid      in   1       upstream sample valid
//  o_ready      out  1       block can accept sample this cycle
//  i_d          in   WIDTH   desired sample (minuend)
//  i_y          in   WIDTH   filter output sample (subtrahend)
//  o_valid      out  1       result valid
//  i_ready      in   1       downstream accepts result
//  o_err        out  WIDTH   d - y (saturated or wrapped, see CONFIGURATION)
//  o_ovr        out  1       overflow occurred on the sample in o_err (qualified by o_valid)
//  o_ovr_sticky out  1       set by any emitted overflow, held until i_clr
//  o_ovr_cnt    out  CNT_W   number of emitted overflows, saturates at all-ones
//  i_clr        in   1       clears o_ovr_sticky and o_ovr_cnt
// BEHAVIOUR
//  - Reset: o_valid=0, o_err=0, o_ovr=0, o_ovr_sticky=0, o_ovr_cnt=0; internal stage-1 valid=0.
//  - Advance enable en = !o_valid || i_ready. o_ready = en (combinational).
//  - Transfer in: i_valid && o_ready. Transfer out: o_valid && i_ready.
//  - Stage 1 (on en): register i_d and i_y; s1_valid <= i_valid.
//  - Stage 2 (on en): o_valid <= s1_valid; compute from the stage-1 operands; update o_err and o_ovr.
//  - Latency: 2 cycles from input transfer to o_valid when unstalled; throughput 1/cycle.
//  - Stall (o_valid && !i_ready): both stages hold; o_err and o_ovr stay stable; o_ready=0.
//  - Bubbles: when s1_valid=0 propagates, o_valid=0. o_err keeps its previous value and is don't-care.
//  - Arithmetic: the difference is computed at WIDTH+1 bits.
//    ovr = (d[MSB] != y[MSB]) && (raw[WIDTH-1] != d[MSB]).
//  - Positive overflow (d>=0, y<0): saturated result is 2^(WIDTH-1)-1.
//    Negative overflow (d<0, y>=0): saturated result is -2^(WIDTH-1).
//  - Statistics update only on an output transfer with o_ovr=1:
//    sticky<=1, cnt<=cnt+1, no wrap past all-ones.
//  - i_clr with no overflow transfer in the same cycle: sticky<=0, cnt<=0.
//    i_clr coinciding with an overflow transfer: sticky<=1, cnt<=1.
//  - Reset asserted mid-operation: all in-flight samples are discarded, with no partial output.
//    o_ready=1 on the first cycle after reset deasserts.
//  - Inputs are sampled only on transfer; i_d and i_y are don't-care otherwise.
// CONFIGURATION
//  FSUB_ERR_SAT_EN defined: on overflow, o_err is the saturated value (see BEHAVIOUR).
//  FSUB_ERR_SAT_EN undefined: o_err is the wrapped WIDTH-bit difference.
//  In both modes, o_ovr, o_ovr_sticky and o_ovr_cnt behave identically.
// TESTING (WIDTH=16, CNT_W=4)
//  - d=0x4000, y=0x2000, i_ready=1 -> 2 cycles later o_valid=1, o_err=0x2000, o_ovr=0.
//  - d=0x7FFF, y=0x8000 -> o_ovr=1, sticky=1, cnt=1; o_err=0x7FFF (SAT_EN) or 0xFFFF (no SAT_EN).
//  - d=0x8000, y=0x0001 -> o_ovr=1; o_err=0x8000 (SAT_EN) or 0x7FFF (no SAT_EN).
//  - Stream 8 samples with i_ready toggling 1,0,0,1 -> all 8 emitted in order, none lost or duplicated;
//    o_err is stable while stalled.
//  - 20 overflow samples -> cnt saturates at 0xF; i_clr alone -> cnt=0, sticky=0;
//    i_clr with an overflow transfer -> cnt=1, sticky=1.
//  - i_rst pulse with 2 samples in flight -> o_valid=0 the next cycle, no stale output;
//    a fresh sample then emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/fsub_err.sv
// Two-stage pipelined error subtractor e = d - y with valid/ready handshakes and overflow statistics.
// Define FSUB_ERR_SAT_EN to saturate on overflow; otherwise the WIDTH-bit difference wraps.
module fsub_err #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 15,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_err,
    output logic             o_ovr,
    output logic             o_ovr_sticky,
    output logic [CNT_W-1:0] o_ovr_cnt,
    input  logic             i_clr
);

    if (FRAC >= WIDTH) begin : g_frac_chk
        $error("fsub_err: FRAC must be smaller than WIDTH");
    end

    logic             en;
    logic [WIDTH:0]   raw;
    logic             ovr;
    logic [WIDTH-1:0] res;
    logic             ovr_xfer;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic             ovr_q, ovr_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        en  = !o_valid_q || i_ready;
        raw = {d_q[WIDTH-1], d_q} - {y_q[WIDTH-1], y_q};
        // The true sign is raw[WIDTH]; overflow iff it differs from the truncated sign bit.
        ovr = raw[WIDTH] != raw[WIDTH-1];
        res = raw[WIDTH-1:0];
`ifdef FSUB_ERR_SAT_EN
        if (ovr) begin
            res = raw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif

        s1_valid_d = s1_valid_q;
        d_d        = d_q;
        y_d        = y_q;
        o_valid_d  = o_valid_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        if (en) begin
            s1_valid_d = i_valid;
            d_d        = i_d;
            y_d        = i_y;
            o_valid_d  = s1_valid_q;
            if (s1_valid_q) begin
                err_d = res;
                ovr_d = ovr;
            end
        end

        ovr_xfer = o_valid_q && i_ready && ovr_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (i_clr) begin
            sticky_d = ovr_xfer;
            cnt_d    = ovr_xfer ? CNT_W'(1) : '0;
        end else if (ovr_xfer) begin
            sticky_d = 1'b1;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            d_q        <= '0;
            y_q        <= '0;
            o_valid_q  <= 1'b0;
            err_q      <= '0;
            ovr_q      <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            d_q        <= d_d;
            y_q        <= y_d;
            o_valid_q  <= o_valid_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_ready      = en;
    assign o_valid      = o_valid_q;
    assign o_err        = err_q;
    assign o_ovr        = ovr_q;
    assign o_ovr_sticky = sticky_q;
    assign o_ovr_cnt    = cnt_q;

endmodule

// File: tb/tb_fsub_err.sv
// Self-checking bench for fsub_err (WIDTH=16, CNT_W=4) with a scoreboard of expected {ovr, err}.
module tb_fsub_err;

    logic        clk;
    logic        i_rst, i_valid, i_ready, i_clr;
    logic [15:0] i_d, i_y;
    logic        o_ready, o_valid, o_ovr, o_ovr_sticky;
    logic [15:0] o_err;
    logic [3:0]  o_ovr_cnt;

    int          total = 0;
    int          bad   = 0;
    int          n_out = 0;
    logic [16:0] sb[$];

    fsub_err #(.WIDTH(16), .FRAC(15), .CNT_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_d          (i_d),
        .i_y          (i_y),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_err        (o_err),
        .o_ovr        (o_ovr),
        .o_ovr_sticky (o_ovr_sticky),
        .o_ovr_cnt    (o_ovr_cnt),
        .i_clr        (i_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer difference, then clamp or wrap to 16 bits.
    function automatic logic [16:0] model(input logic [15:0] d, input logic [15:0] y);
        int          diff;
        logic        ov;
        logic [15:0] e;
        diff = int'($signed(d)) - int'($signed(y));
        ov   = (diff > 32767) || (diff < -32768);
        e    = diff[15:0];
`ifdef FSUB_ERR_SAT_EN
        if (ov) e = (diff > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {ov, e};
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer.
    always @(negedge clk) begin
        if (i_rst === 1'b1) begin
            sb.delete();
        end else begin
            if (o_valid && i_ready) begin
                total++;
                n_out++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got ovr=%b err=%h, no result expected", o_ovr, o_err);
                end else begin
                    logic [16:0] exp;
                    exp = sb.pop_front();
                    if ({o_ovr, o_err} !== exp) begin
                        bad++;
                        $display("FAIL sb_result: got ovr=%b err=%h exp ovr=%b err=%h",
                                 o_ovr, o_err, exp[16], exp[15:0]);
                    end
                end
            end
            if (i_valid && o_ready) sb.push_back(model(i_d, i_y));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0; i_d = '0; i_y = '0;
        repeat (3) tick();
        total++;
        if ({o_valid, o_err, o_ovr, o_ovr_sticky, o_ovr_cnt} !== 23'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b err=%h ovr=%b st=%b cnt=%h exp all zero",
                     o_valid, o_err, o_ovr, o_ovr_sticky, o_ovr_cnt);
        end
        i_rst = 1'b0;
        #1;
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", o_ready); end
    endtask

    task automatic test_basic();
        i_d = 16'h4000; i_y = 16'h2000; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1: got valid=%b exp 0", o_valid); end
        tick();
        total++;
        if ({o_valid, o_ovr, o_err} !== {1'b1, 1'b0, 16'h2000}) begin
            bad++;
            $display("FAIL basic_lat2: got v=%b ovr=%b err=%h exp v=1 ovr=0 err=2000", o_valid, o_ovr, o_err);
        end
        tick();
        total++;
        if ({o_valid, o_ovr_sticky, o_ovr_cnt} !== 6'b0_0_0000) begin
            bad++;
            $display("FAIL basic_stats: got v=%b st=%b cnt=%h exp 0 0 0", o_valid, o_ovr_sticky, o_ovr_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_pos, exp_neg;
`ifdef FSUB_ERR_SAT_EN
        exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
        exp_pos = 16'hFFFF; exp_neg = 16'h7FFF;
`endif
        i_ready = 1'b1;
        i_d = 16'h7FFF; i_y = 16'h8000; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        total++;
        if ({o_valid, o_ovr, o_err, o_ovr_sticky} !== {1'b1, 1'b1, exp_pos, 1'b0}) begin
            bad++;
            $display("FAIL ovr_pos: got v=%b ovr=%b err=%h st=%b exp v=1 ovr=1 err=%h st=0",
                     o_valid, o_ovr, o_err, o_ovr_sticky, exp_pos);
        end
        tick();
        total++;
        if ({o_ovr_sticky, o_ovr_cnt} !== 5'b1_0001) begin
            bad++;
            $display("FAIL ovr_pos_stats: got st=%b cnt=%h exp st=1 cnt=1", o_ovr_sticky, o_ovr_cnt);
        end
        i_d = 16'h8000; i_y = 16'h0001; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        total++;
        if ({o_valid, o_ovr, o_err} !== {1'b1, 1'b1, exp_neg}) begin
            bad++;
            $display("FAIL ovr_neg: got v=%b ovr=%b err=%h exp v=1 ovr=1 err=%h", o_valid, o_ovr, o_err, exp_neg);
        end
        tick();
        total++;
        if (o_ovr_cnt !== 4'd2) begin bad++; $display("FAIL ovr_neg_cnt: got %h exp 2", o_ovr_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ds[8], ys[8];
        int          pat[4] = '{1, 0, 0, 1};
        int          k = 0, c = 0, n0;
        logic        acc, st, povr;
        logic [15:0] perr;
        for (int i = 0; i < 8; i++) begin
            ds[i] = 16'($urandom);
            ys[i] = 16'($urandom);
        end
        ds[3] = 16'h7000; ys[3] = 16'h9000;
        n0 = n_out;
        while ((k < 8 || sb.size() != 0 || o_valid) && c < 200) begin
            i_ready = pat[c % 4][0];
            i_valid = (k < 8);
            i_d = ds[k % 8];
            i_y = ys[k % 8];
            @(negedge clk);
            acc  = i_valid && o_ready;
            st   = o_valid && !i_ready;
            perr = o_err;
            povr = o_ovr;
            if (st) begin
                total++;
                if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b exp 0", o_ready); end
            end
            tick();
            if (st) begin
                total++;
                if ({o_valid, o_ovr, o_err} !== {1'b1, povr, perr}) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b ovr=%b err=%h exp v=1 ovr=%b err=%h",
                             o_valid, o_ovr, o_err, povr, perr);
                end
            end
            if (acc) k++;
            c++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        total++;
        if (c >= 200) begin bad++; $display("FAIL stream_timeout: cycles=%0d limit 200", c); end
        total++;
        if (n_out - n0 !== 8) begin bad++; $display("FAIL stream_count: got %0d exp 8", n_out - n0); end
    endtask

    task automatic test_stats();
        int n = 0;
        i_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_valid = 1'b1;
            i_d = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
            i_y = (i % 2 == 0) ? 16'h8000 : 16'h0001;
            tick();
        end
        i_valid = 1'b0;
        repeat (3) tick();
        total++;
        if ({o_ovr_sticky, o_ovr_cnt} !== 5'b1_1111) begin
            bad++;
            $display("FAIL cnt_saturate: got st=%b cnt=%h exp st=1 cnt=f", o_ovr_sticky, o_ovr_cnt);
        end
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        total++;
        if ({o_ovr_sticky, o_ovr_cnt} !== 5'b0_0000) begin
            bad++;
            $display("FAIL clr_alone: got st=%b cnt=%h exp st=0 cnt=0", o_ovr_sticky, o_ovr_cnt);
        end
        i_d = 16'h8000; i_y = 16'h7FFF; i_valid = 1'b1;
        repeat (2) tick();
        i_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (o_ovr_cnt !== 4'd2) begin bad++; $display("FAIL cnt_after_clr: got %h exp 2", o_ovr_cnt); end
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        while (o_valid !== 1'b1 && n < 10) begin tick(); n++; end
        total++;
        if (n >= 10) begin bad++; $display("FAIL clr_wait_timeout: cycles=%0d limit 10", n); end
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        total++;
        if ({o_ovr_sticky, o_ovr_cnt} !== 5'b1_0001) begin
            bad++;
            $display("FAIL clr_with_ovr: got st=%b cnt=%h exp st=1 cnt=1", o_ovr_sticky, o_ovr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        i_valid = 1'b1; i_d = 16'h1000; i_y = 16'h0100;
        tick();
        i_d = 16'h0200; i_y = 16'h0300;
        tick();
        i_valid = 1'b0;
        total++;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_inflight: got v=%b exp 1", o_valid); end
        i_rst = 1'b1;
        tick();
        total++;
        if ({o_valid, o_ovr_sticky, o_ovr_cnt} !== 6'd0) begin
            bad++;
            $display("FAIL rst_mid_flush: got v=%b st=%b cnt=%h exp 0 0 0", o_valid, o_ovr_sticky, o_ovr_cnt);
        end
        i_rst = 1'b0;
        #1;
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b exp 1", o_ready); end
        tick();
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale: got v=%b exp 0", o_valid); end
        i_valid = 1'b1; i_d = 16'hFF00; i_y = 16'h0100;
        tick();
        i_valid = 1'b0;
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_fresh_lat1: got v=%b exp 0", o_valid); end
        tick();
        total++;
        if ({o_valid, o_ovr, o_err} !== {1'b1, 1'b0, 16'hFE00}) begin
            bad++;
            $display("FAIL rst_fresh_lat2: got v=%b ovr=%b err=%h exp v=1 ovr=0 err=fe00", o_valid, o_ovr, o_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_stats();
        repeat (3) tick();
        test_reset_mid();
        repeat (2) tick();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending exp 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
